// File: rtl/v_pkg.sv
// Shared types and encodings for the vector decode/sequencer slice.
// Contents: vtype_t, dseq_state_t, uop_t, SEW_*/VLMUL_* constants, opcode/funct fields,
//           uop control encodings and a reserved-vtype helper.
package v_pkg;

  localparam logic [6:0] OPC_OPV = 7'b1010111;

  localparam logic [2:0] F3_IVV = 3'b000;
  localparam logic [2:0] F3_MVV = 3'b010;
  localparam logic [2:0] F3_IVI = 3'b011;
  localparam logic [2:0] F3_IVX = 3'b100;
  localparam logic [2:0] F3_CFG = 3'b111;

  localparam logic [5:0] F6_ADD  = 6'b000000;
  localparam logic [5:0] F6_SUB  = 6'b000010;
  localparam logic [5:0] F6_AND  = 6'b001001;
  localparam logic [5:0] F6_OR   = 6'b001010;
  localparam logic [5:0] F6_XOR  = 6'b001011;
  localparam logic [5:0] F6_SLUP = 6'b001110;
  localparam logic [5:0] F6_SLDN = 6'b001111;
  localparam logic [5:0] F6_MV   = 6'b010111;
  localparam logic [5:0] F6_MUL  = 6'b100101;
  localparam logic [5:0] F6_RSUM = 6'b000000;
  localparam logic [5:0] F6_RAND = 6'b000001;
  localparam logic [5:0] F6_ROR  = 6'b000010;
  localparam logic [5:0] F6_RXOR = 6'b000011;

  localparam logic [2:0] SEW_8  = 3'd0;
  localparam logic [2:0] SEW_16 = 3'd1;
  localparam logic [2:0] SEW_32 = 3'd2;

  localparam logic [2:0] VLMUL_1    = 3'd0;
  localparam logic [2:0] VLMUL_2    = 3'd1;
  localparam logic [2:0] VLMUL_4    = 3'd2;
  localparam logic [2:0] VLMUL_8    = 3'd3;
  localparam logic [2:0] VLMUL_RSVD = 3'd4;
  localparam logic [2:0] VLMUL_F8   = 3'd5;
  localparam logic [2:0] VLMUL_F4   = 3'd6;
  localparam logic [2:0] VLMUL_F2   = 3'd7;

  localparam logic [3:0] ALU_NOP = 4'd0;
  localparam logic [3:0] ALU_ADD = 4'd1;
  localparam logic [3:0] ALU_SUB = 4'd2;
  localparam logic [3:0] ALU_AND = 4'd3;
  localparam logic [3:0] ALU_OR  = 4'd4;
  localparam logic [3:0] ALU_XOR = 4'd5;
  localparam logic [3:0] ALU_MV  = 4'd6;
  localparam logic [3:0] ALU_MUL = 4'd7;

  localparam logic [2:0] RED_NONE = 3'd0;
  localparam logic [2:0] RED_SUM  = 3'd1;
  localparam logic [2:0] RED_AND  = 3'd2;
  localparam logic [2:0] RED_OR   = 3'd3;
  localparam logic [2:0] RED_XOR  = 3'd4;

  localparam logic [2:0] SLDU_NONE = 3'd0;
  localparam logic [2:0] SLDU_UP   = 3'd1;
  localparam logic [2:0] SLDU_DOWN = 3'd2;

  localparam logic [3:0] LSU_NONE = 4'd0;

  localparam logic [2:0] OPA_VS1 = 3'd0;
  localparam logic [2:0] OPA_RS1 = 3'd1;
  localparam logic [2:0] OPA_IMM = 3'd2;
  localparam logic [1:0] OPB_VS2 = 2'd0;
  localparam logic [1:0] DEST_VRF = 2'd0;

  typedef struct packed {
    logic       vill;
    logic [2:0] vsew;
    logic [2:0] vlmul;
  } vtype_t;

  typedef enum logic {IDLE, EXPAND} dseq_state_t;

  typedef struct packed {
    logic [3:0] alu_op;
    logic       is_mul;
    logic [2:0] red_op;
    logic [2:0] sldu_op;
    logic [3:0] lsu_op;
    logic [2:0] op_sel_a;
    logic [1:0] op_sel_b;
    logic [1:0] sel_dest;
  } uop_t;

  // SEW above 32 and the LMUL encoding 4 are not supported configurations.
  function automatic logic vtype_reserved(input logic [2:0] vsew_f, input logic [2:0] vlmul_f);
    return (vsew_f > SEW_32) || (vlmul_f == VLMUL_RSVD);
  endfunction

endpackage

// File: rtl/v_vl_calc.sv
// Purpose: combinational vtype/vl update for vsetvli (VLMAX = VLEN/SEW*LMUL, then AVL select).
// Latency: 0 cycles (pure combinational).  Backpressure: none.
// Ports: zimm_vsew/zimm_vlmul from the instruction, rs1_data/rs1_zero/rd_zero, vl_cur in; vtype_nx, vl_nx out.
module v_vl_calc
  import v_pkg::*;
#(
  parameter int VLEN = 128,
  parameter int XLEN = 32
) (
  input  logic [2:0]               zimm_vsew,
  input  logic [2:0]               zimm_vlmul,
  input  logic [XLEN-1:0]          rs1_data,
  input  logic                     rs1_zero,
  input  logic                     rd_zero,
  input  logic [$clog2(VLEN/8):0]  vl_cur,
  output vtype_t                   vtype_nx,
  output logic [$clog2(VLEN/8):0]  vl_nx
);

  localparam int MAXW = $clog2(VLEN) + 1;
  localparam int VL_W = $clog2(VLEN/8) + 1;

  logic [MAXW-1:0] base;
  logic [MAXW-1:0] vlmax;
  logic [XLEN-1:0] vlmax_x;
  logic [XLEN-1:0] avl;

  always_comb begin
    // VLEN/SEW with SEW = 8 << vsew; vsew[2] only matters for the reserved check.
    base = MAXW'(VLEN/8) >> zimm_vsew[1:0];
    if (zimm_vlmul[2]) begin
      // mf8/mf4/mf2 encode as 5/6/7: divide by 8/4/2.
      vlmax = base >> (3'd4 - {1'b0, zimm_vlmul[1:0]});
    end else begin
      vlmax = base << zimm_vlmul[1:0];
    end
    vlmax_x = XLEN'(vlmax);

    if (!rs1_zero) begin
      avl = (rs1_data < vlmax_x) ? rs1_data : vlmax_x;
    end else if (!rd_zero) begin
      avl = vlmax_x;
    end else begin
      avl = XLEN'(vl_cur);
    end

    // The vl port only spans VLEN/8; larger VLMAX values (small SEW, LMUL>1) saturate.
    if (avl > XLEN'({VL_W{1'b1}})) begin
      vl_nx = '1;
    end else begin
      vl_nx = avl[VL_W-1:0];
    end

    vtype_nx.vill  = 1'b0;
    vtype_nx.vsew  = zimm_vsew;
    vtype_nx.vlmul = zimm_vlmul;
    if (vtype_reserved(zimm_vsew, zimm_vlmul)) begin
      vtype_nx = '{vill: 1'b1, vsew: 3'd0, vlmul: 3'd0};
      vl_nx    = '0;
    end
  end

endmodule

// File: rtl/v_decode_seq.sv
// Purpose: decode RVV instructions and expand LMUL register groups into one uop per register.
// Latency: first uop valid 1 cycle after accept; vsetvli updates vtype/vl 1 cycle after accept.
// Backpressure: uop outputs hold while out_valid & !out_ready; in_ready only in IDLE or on the last uop handshake.
// Ports: clk/rst (sync, active-high); in_valid/in_ready/instr/rs1_data; out_valid/out_ready + uop_*; vl/vsew/vlmul/vill/illegal.
module v_decode_seq
  import v_pkg::*;
#(
  parameter int VLEN = 128,
  parameter int XLEN = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [31:0]             instr,
  input  logic [XLEN-1:0]         rs1_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [3:0]              uop_alu_op,
  output logic                    uop_is_mul,
  output logic [2:0]              uop_red_op,
  output logic [2:0]              uop_sldu_op,
  output logic [3:0]              uop_lsu_op,
  output logic [2:0]              uop_op_sel_A,
  output logic [1:0]              uop_op_sel_B,
  output logic [1:0]              uop_sel_dest,
  output logic [4:0]              uop_vd,
  output logic [4:0]              uop_vs1,
  output logic [4:0]              uop_vs2,
  output logic [2:0]              uop_idx,
  output logic                    uop_last,
  output logic [$clog2(VLEN/8):0] vl,
  output logic [2:0]              vsew,
  output logic [2:0]              vlmul,
  output logic                    vill,
  output logic                    illegal
);

  localparam int VL_W = $clog2(VLEN/8) + 1;

  dseq_state_t state, state_nx;
  logic [2:0]  idx, last_idx;
  logic [4:0]  vd_q, vs1_q, vs2_q;
  logic        vs1_reg_q;
  uop_t        ctrl_q, dec_ctrl;
  vtype_t      vtype_q, vtype_nx;
  logic [VL_W-1:0] vl_q, vl_nx;
  logic        illegal_q;

  logic [6:0] opcode;
  logic [2:0] f3;
  logic [5:0] funct6;
  logic [4:0] dec_vd, dec_vs1, dec_vs2;
  logic       dec_ok, dec_cfg, dec_single, dec_vs1_reg;
  logic [2:0] grp_mask;
  logic       misalign, vd_over, bad, accept, launch, cfg_acc;

  assign opcode  = instr[6:0];
  assign dec_vd  = instr[11:7];
  assign f3      = instr[14:12];
  assign dec_vs1 = instr[19:15];
  assign dec_vs2 = instr[24:20];
  assign funct6  = instr[31:26];

  always_comb begin
    dec_ctrl   = '0;
    dec_ok     = 1'b0;
    dec_cfg    = 1'b0;
    dec_single = 1'b0;
    if (opcode == OPC_OPV) begin
      case (f3)
        F3_CFG: begin
          // Only vsetvli (instr[31]==0) is supported.
          dec_cfg = !instr[31];
          dec_ok  = !instr[31];
        end
        F3_IVV, F3_IVX, F3_IVI: begin
          dec_ok = 1'b1;
          dec_ctrl.op_sel_a = (f3 == F3_IVV) ? OPA_VS1 : ((f3 == F3_IVX) ? OPA_RS1 : OPA_IMM);
          case (funct6)
            F6_ADD:  dec_ctrl.alu_op = ALU_ADD;
            F6_SUB:  dec_ctrl.alu_op = ALU_SUB;
            F6_AND:  dec_ctrl.alu_op = ALU_AND;
            F6_OR:   dec_ctrl.alu_op = ALU_OR;
            F6_XOR:  dec_ctrl.alu_op = ALU_XOR;
            F6_SLUP: begin
              dec_ctrl.sldu_op = SLDU_UP;
              dec_ok = (f3 != F3_IVV);
            end
            F6_SLDN: begin
              dec_ctrl.sldu_op = SLDU_DOWN;
              dec_ok = (f3 != F3_IVV);
            end
            F6_MV: begin
              // vmv.v.*: unmasked with vs2 field zero; vmerge is not supported.
              dec_ctrl.alu_op = ALU_MV;
              dec_single = 1'b1;
              dec_ok = instr[25] && (dec_vs2 == 5'd0);
            end
            default: dec_ok = 1'b0;
          endcase
        end
        F3_MVV: begin
          dec_ok = 1'b1;
          dec_ctrl.op_sel_a = OPA_VS1;
          case (funct6)
            F6_MUL: begin
              dec_ctrl.alu_op = ALU_MUL;
              dec_ctrl.is_mul = 1'b1;
            end
            F6_RSUM: begin dec_ctrl.red_op = RED_SUM; dec_single = 1'b1; end
            F6_RAND: begin dec_ctrl.red_op = RED_AND; dec_single = 1'b1; end
            F6_ROR:  begin dec_ctrl.red_op = RED_OR;  dec_single = 1'b1; end
            F6_RXOR: begin dec_ctrl.red_op = RED_XOR; dec_single = 1'b1; end
            default: dec_ok = 1'b0;
          endcase
        end
        default: dec_ok = 1'b0;
      endcase
    end
    dec_ctrl.op_sel_b = OPB_VS2;
    dec_ctrl.sel_dest = DEST_VRF;
    dec_ctrl.lsu_op   = LSU_NONE;
  end

  assign dec_vs1_reg = (dec_ctrl.op_sel_a == OPA_VS1);

  // Group size minus one, from the live vtype (fractional LMUL and single-uop ops use 1 register).
  always_comb begin
    grp_mask = 3'd0;
    if (!dec_single && !vtype_q.vlmul[2]) begin
      case (vtype_q.vlmul[1:0])
        2'd1:    grp_mask = 3'd1;
        2'd2:    grp_mask = 3'd3;
        2'd3:    grp_mask = 3'd7;
        default: grp_mask = 3'd0;
      endcase
    end
  end

  assign misalign = (|(dec_vd & {2'b00, grp_mask})) || (|(dec_vs2 & {2'b00, grp_mask})) ||
                    (dec_vs1_reg && (|(dec_vs1 & {2'b00, grp_mask})));
  assign vd_over  = ({1'b0, dec_vd} + {3'b000, grp_mask} + 6'd1) > 6'd32;
  assign bad      = !dec_ok || (!dec_cfg && (vtype_q.vill || misalign || vd_over));

  assign uop_last = (state == EXPAND) && (idx == last_idx);
  assign in_ready = (state == IDLE) || ((state == EXPAND) && uop_last && out_ready);
  assign accept   = in_valid && in_ready;
  assign launch   = accept && !bad && !dec_cfg;
  assign cfg_acc  = accept && !bad && dec_cfg;

  v_vl_calc #(.VLEN(VLEN), .XLEN(XLEN)) u_vl_calc (
    .zimm_vsew (instr[25:23]),
    .zimm_vlmul(instr[22:20]),
    .rs1_data  (rs1_data),
    .rs1_zero  (dec_vs1 == 5'd0),
    .rd_zero   (dec_vd == 5'd0),
    .vl_cur    (vl_q),
    .vtype_nx  (vtype_nx),
    .vl_nx     (vl_nx)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        if (launch) state_nx = EXPAND;
      end
      EXPAND: begin
        out_valid = 1'b1;
        if (out_ready && uop_last) state_nx = launch ? EXPAND : IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx       <= 3'd0;
      last_idx  <= 3'd0;
      vd_q      <= 5'd0;
      vs1_q     <= 5'd0;
      vs2_q     <= 5'd0;
      vs1_reg_q <= 1'b0;
      ctrl_q    <= '0;
      vtype_q   <= '0;
      vl_q      <= '0;
      illegal_q <= 1'b0;
    end else begin
      illegal_q <= accept && bad;
      if (cfg_acc) begin
        vtype_q <= vtype_nx;
        vl_q    <= vl_nx;
      end
      if (launch) begin
        // The group size is frozen here, so a later vsetvli cannot disturb this group.
        idx       <= 3'd0;
        last_idx  <= grp_mask;
        vd_q      <= dec_vd;
        vs1_q     <= dec_vs1;
        vs2_q     <= dec_vs2;
        vs1_reg_q <= dec_vs1_reg;
        ctrl_q    <= dec_ctrl;
      end else if ((state == EXPAND) && out_ready && !uop_last) begin
        idx <= idx + 3'd1;
      end
    end
  end

  assign uop_alu_op   = ctrl_q.alu_op;
  assign uop_is_mul   = ctrl_q.is_mul;
  assign uop_red_op   = ctrl_q.red_op;
  assign uop_sldu_op  = ctrl_q.sldu_op;
  assign uop_lsu_op   = ctrl_q.lsu_op;
  assign uop_op_sel_A = ctrl_q.op_sel_a;
  assign uop_op_sel_B = ctrl_q.op_sel_b;
  assign uop_sel_dest = ctrl_q.sel_dest;
  assign uop_vd       = vd_q + {2'b00, idx};
  assign uop_vs2      = vs2_q + {2'b00, idx};
  assign uop_vs1      = vs1_reg_q ? (vs1_q + {2'b00, idx}) : vs1_q;
  assign uop_idx      = idx;
  assign vl           = vl_q;
  assign vsew         = vtype_q.vsew;
  assign vlmul        = vtype_q.vlmul;
  assign vill         = vtype_q.vill;
  assign illegal      = illegal_q;

endmodule

// File: tb/tb_v_decode_seq.sv
module tb_v_decode_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] instr;
  logic [31:0] rs1_data;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  uop_alu_op;
  logic        uop_is_mul;
  logic [2:0]  uop_red_op;
  logic [2:0]  uop_sldu_op;
  logic [3:0]  uop_lsu_op;
  logic [2:0]  uop_op_sel_A;
  logic [1:0]  uop_op_sel_B;
  logic [1:0]  uop_sel_dest;
  logic [4:0]  uop_vd, uop_vs1, uop_vs2;
  logic [2:0]  uop_idx;
  logic        uop_last;
  logic [4:0]  vl;
  logic [2:0]  vsew, vlmul;
  logic        vill, illegal;

  int total = 0;
  int bad   = 0;

  v_decode_seq #(.VLEN(128), .XLEN(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .instr(instr), .rs1_data(rs1_data), .out_valid(out_valid), .out_ready(out_ready),
    .uop_alu_op(uop_alu_op), .uop_is_mul(uop_is_mul), .uop_red_op(uop_red_op),
    .uop_sldu_op(uop_sldu_op), .uop_lsu_op(uop_lsu_op), .uop_op_sel_A(uop_op_sel_A),
    .uop_op_sel_B(uop_op_sel_B), .uop_sel_dest(uop_sel_dest), .uop_vd(uop_vd),
    .uop_vs1(uop_vs1), .uop_vs2(uop_vs2), .uop_idx(uop_idx), .uop_last(uop_last),
    .vl(vl), .vsew(vsew), .vlmul(vlmul), .vill(vill), .illegal(illegal)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] opv(input logic [5:0] f6, input logic [4:0] vs2,
                                      input logic [4:0] vs1, input logic [2:0] f3, input logic [4:0] vd);
    return {f6, 1'b1, vs2, vs1, f3, vd, 7'b1010111};
  endfunction

  function automatic logic [31:0] vsetvli(input logic [4:0] rd, input logic [4:0] rs1, input logic [10:0] zimm);
    return {1'b0, zimm, rs1, 3'b111, rd, 7'b1010111};
  endfunction

  // Drive one instruction for a single cycle.
  task automatic issue(input logic [31:0] ins, input logic [31:0] rs1v);
    instr    = ins;
    rs1_data = rs1v;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; instr = '0; rs1_data = '0;
    tick(); tick();
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_in_ready", 32'(in_ready), 1);
    check("rst_vl", 32'(vl), 0);
    check("rst_vtype", {vill, vsew, vlmul}, 0);
    check("rst_illegal", 32'(illegal), 0);
    check("rst_uop", {uop_vd, uop_vs1, uop_vs2, uop_idx, uop_last, uop_alu_op}, 0);
    rst = 1'b0;
    tick();

    // vsetvli x1, x5, e32,m2 with AVL 20 -> VLMAX 8
    issue(vsetvli(5'd1, 5'd5, 11'h011), 32'd20);
    check("cfg_vl", 32'(vl), 8);
    check("cfg_vsew", 32'(vsew), 2);
    check("cfg_vlmul", 32'(vlmul), 1);
    check("cfg_no_uop", 32'(out_valid), 0);

    // vadd.vv v4,v8,v12 under m2, no stall
    out_ready = 1'b1;
    instr = opv(6'b000000, 5'd8, 5'd12, 3'b000, 5'd4);
    check("add_in_ready_idle", 32'(in_ready), 1);
    issue(instr, 32'd0);
    check("add0_valid", 32'(out_valid), 1);
    check("add0_regs", {uop_vd, uop_vs2, uop_vs1}, {17'd0, 5'd4, 5'd8, 5'd12});
    check("add0_idx_last", {uop_idx, uop_last}, {3'd0, 1'b0});
    check("add0_in_ready", 32'(in_ready), 0);
    check("add0_ctrl", {uop_alu_op, uop_op_sel_A, uop_is_mul}, {4'd1, 3'd0, 1'b0});
    tick();
    check("add1_regs", {uop_vd, uop_vs2, uop_vs1}, {17'd0, 5'd5, 5'd9, 5'd13});
    check("add1_idx_last", {uop_idx, uop_last}, {3'd1, 1'b1});
    check("add1_in_ready", 32'(in_ready), 1);
    tick();
    check("add_done_idle", 32'(out_valid), 0);

    // Same vadd with 3 stalled cycles on idx0
    out_ready = 1'b0;
    issue(opv(6'b000000, 5'd8, 5'd12, 3'b000, 5'd4), 32'd0);
    for (int i = 0; i < 3; i++) begin
      check("stall_valid", 32'(out_valid), 1);
      check("stall_regs", {uop_vd, uop_vs2, uop_vs1, uop_idx}, {12'd0, 5'd4, 5'd8, 5'd12, 3'd0});
      check("stall_in_ready", 32'(in_ready), 0);
      tick();
    end
    out_ready = 1'b1;
    check("stall_release_idx", 32'(uop_idx), 0);
    tick();
    check("after_stall_idx", {uop_vd, uop_idx, uop_last}, {23'd0, 5'd5, 3'd1, 1'b1});

    // Back-to-back: vsub.vx v16,v20,x7 accepted on the last uop handshake
    instr = opv(6'b000010, 5'd20, 5'd7, 3'b100, 5'd16);
    check("b2b_in_ready", 32'(in_ready), 1);
    issue(instr, 32'd99);
    check("b2b0_valid", 32'(out_valid), 1);
    check("b2b0_regs", {uop_vd, uop_vs2, uop_vs1, uop_idx}, {12'd0, 5'd16, 5'd20, 5'd7, 3'd0});
    check("b2b0_ctrl", {uop_alu_op, uop_op_sel_A}, {4'd2, 3'd1});
    tick();
    check("b2b1_regs", {uop_vd, uop_vs2, uop_vs1, uop_idx, uop_last}, {11'd0, 5'd17, 5'd21, 5'd7, 3'd1, 1'b1});
    tick();
    check("b2b_idle", 32'(out_valid), 0);

    // Misaligned vd=3 under m2
    issue(opv(6'b000000, 5'd8, 5'd12, 3'b000, 5'd3), 32'd0);
    check("misalign_illegal", 32'(illegal), 1);
    check("misalign_no_uop", 32'(out_valid), 0);
    tick();
    check("misalign_pulse_end", 32'(illegal), 0);
    check("misalign_still_idle", 32'(out_valid), 0);

    // vredsum.vs v3,v8,v1 is a single uop regardless of m2, so odd vd is fine
    issue(opv(6'b000000, 5'd8, 5'd1, 3'b010, 5'd3), 32'd0);
    check("red_illegal", 32'(illegal), 0);
    check("red_uop", {uop_vd, uop_vs2, uop_vs1, uop_idx, uop_last, uop_red_op},
          {10'd0, 5'd3, 5'd8, 5'd1, 3'd0, 1'b1, 3'd1});
    tick();
    check("red_done", 32'(out_valid), 0);

    // rs1=x0, rd=x0: vl unchanged (stays 8), vtype e32,m1
    issue(vsetvli(5'd0, 5'd0, 11'h010), 32'd5);
    check("keep_vl", 32'(vl), 8);
    check("keep_vlmul", 32'(vlmul), 0);
    // rs1=x0, rd!=0, e16,mf2: vl = VLMAX = 128/16/2 = 4
    issue(vsetvli(5'd1, 5'd0, 11'h00F), 32'd5);
    check("vlmax_frac", {vl, vsew, vlmul}, {21'd0, 5'd4, 3'd1, 3'd7});
    // AVL 3 under e32,m4 (VLMAX 16)
    issue(vsetvli(5'd1, 5'd5, 11'h012), 32'd3);
    check("avl_small", {vl, vlmul}, {24'd0, 5'd3, 3'd2});

    // Reserved vlmul=4 -> vill
    issue(vsetvli(5'd1, 5'd5, 11'h014), 32'd10);
    check("vill_set", {vill, vl, vsew, vlmul}, {20'd0, 1'b1, 5'd0, 3'd0, 3'd0});
    issue(opv(6'b000000, 5'd8, 5'd12, 3'b000, 5'd4), 32'd0);
    check("vill_add_illegal", 32'(illegal), 1);
    check("vill_add_no_uop", 32'(out_valid), 0);

    // e32,m4 with AVL 100 clamps to VLMAX 16 and clears vill
    issue(vsetvli(5'd1, 5'd5, 11'h012), 32'd100);
    check("clamp_vl", {vill, vl}, {26'd0, 1'b0, 5'd16});
    issue(opv(6'b000000, 5'd16, 5'd24, 3'b000, 5'd8), 32'd0);
    check("m4_0", {uop_vd, uop_idx, uop_last}, {23'd0, 5'd8, 3'd0, 1'b0});
    tick();
    check("m4_1", {uop_vd, uop_vs2, uop_vs1, uop_idx}, {12'd0, 5'd9, 5'd17, 5'd25, 3'd1});
    rst = 1'b1;
    tick();
    check("midrst_out_valid", 32'(out_valid), 0);
    check("midrst_vl", 32'(vl), 0);
    check("midrst_in_ready", 32'(in_ready), 1);
    check("midrst_uop", {uop_vd, uop_idx}, 0);
    rst = 1'b0;
    tick();
    tick();
    check("postrst_no_uop", 32'(out_valid), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/v_decode_seq.md
V_DECODE_SEQ -- requirements
Module: v_decode_seq

Interface
REQ-001 SHALL have parameter VLEN, default 128: vector register length in bits, a power of two from 64 to 1024.
REQ-002 SHALL have parameter XLEN, default 32: scalar operand width.
REQ-003 SHALL have ports: clk, in, 1, clock; one clock domain, all state updates on the rising edge.
REQ-004 SHALL have ports: rst, in, 1, reset; synchronous, active-high.
REQ-005 SHALL have ports: in_valid in 1, in_ready out 1, instr in 32, rs1_data in XLEN; instruction input handshake.
REQ-006 SHALL have ports: out_valid out 1, out_ready in 1; micro-op (uop) output handshake.
REQ-007 SHALL have ports: uop_alu_op out 4, uop_is_mul out 1, uop_red_op out 3, uop_sldu_op out 3, uop_lsu_op out 4, uop_op_sel_A out 3, uop_op_sel_B out 2, uop_sel_dest out 2; existing v_pkg encodings.
REQ-008 SHALL have ports: uop_vd, uop_vs1, uop_vs2 out 5 each; uop_idx out 3; uop_last out 1.
REQ-009 SHALL have ports: vl out $clog2(VLEN/8)+1, vsew out 3, vlmul out 3, vill out 1, illegal out 1.

Function
REQ-010 SHALL use an FSM with states IDLE and EXPAND.
REQ-011 SHALL drive in_ready = (state==IDLE) | (state==EXPAND & uop_last & out_ready).
REQ-012 SHALL treat in_valid & in_ready as an accept; an accepted legal non-vconfig instruction latches instr and rs1_data, sets idx=0 and enters EXPAND.
REQ-013 SHALL make the first uop valid the cycle after accept (latency 1).
REQ-014 SHALL assert out_valid in EXPAND only, and out_valid SHALL be 0 in IDLE.
REQ-015 SHALL set group size N=2^vlmul for vlmul in 0..3; for fractional vlmul (5..7), N=1.
REQ-016 SHALL, for each uop k in 0..N-1, output uop_vd=vd+k, uop_vs2=vs2+k, uop_vs1=vs1+k when op_sel_A selects vs1 (otherwise raw instr[19:15]), uop_idx=k, and uop_last=(k==N-1).
REQ-017 SHALL exempt reductions and vmv: they SHALL emit a single uop with N=1 regardless of vlmul.
REQ-018 SHALL hold all uop outputs stable while out_valid & !out_ready.
REQ-019 SHALL, in EXPAND, on out_valid & out_ready with !uop_last, increment idx.
REQ-020 SHALL, on out_valid & out_ready with uop_last, return to IDLE, unless a new instruction is accepted the same cycle, in which case EXPAND is re-entered with idx=0 (back-to-back, no bubble).
REQ-021 SHALL, for vsetvli (vconfig), consume the instruction and emit no uop; vsew, vlmul and vill SHALL update the cycle after accept from zimm instr[30:20].
REQ-022 SHALL compute VLMAX = VLEN/SEW*LMUL; fractional LMUL divides.
REQ-023 SHALL set vl = min(rs1_data, VLMAX) when rs1!=0.
REQ-024 SHALL set vl = VLMAX when rs1==0 and rd!=0.
REQ-025 SHALL leave vl unchanged when rs1==0 and rd==0.
REQ-026 SHALL treat vsew>2 (SEW>32) or vlmul==4 as reserved: set vill=1, vl=0, vsew=0, vlmul=0.
REQ-027 SHALL, for a uop group in flight, keep using the latched vlmul; a vconfig accepted on its last handshake affects only later instructions.
REQ-028 SHALL pulse illegal for exactly 1 cycle after accepting an instruction that is one of: unrecognised opcode/funct; any non-vconfig while vill=1; vd, vs1 or vs2 not a multiple of N when N>1; vd+N>32. Such an instruction SHALL emit no uop and the FSM SHALL stay in/return to IDLE.

Reset
REQ-029 SHALL, with rst high at a clock edge, force: state IDLE, out_valid=0, idx=0, illegal=0, vl=0, vsew=0, vlmul=0, vill=0, and all uop fields 0.
REQ-030 SHALL abandon any group in flight on reset mid-EXPAND, with no further uops emitted.
REQ-031 SHALL give rst priority over a simultaneous accept or handshake.

Structure
REQ-032 SHALL place in v_pkg: vtype_t struct (vill, vsew, vlmul), dseq_state_t enum, VLMUL_* and SEW_* constants, uop_t struct.
REQ-033 SHALL implement the VLMAX/vl computation in one combinational sub-module, v_vl_calc.
REQ-034 SHALL contain no other sub-modules; decode logic is local.

Verification
REQ-035 SHALL cover: vsetvli e32,m2 with rs1_data=20 (VLEN=128) -> vl=8, vsew=2, vlmul=1, no out_valid.
REQ-036 SHALL cover: then vadd.vv v4,v8,v12 with out_ready=1 -> uop (4,8,12,idx0,last0), then (5,9,13,idx1,last1), in_ready=1 on the second.
REQ-037 SHALL cover: same vadd with out_ready=0 for 3 cycles on idx0 -> outputs constant, in_ready=0, idx0 emitted once.
REQ-038 SHALL cover: vadd.vv v3,v8,v12 under m2 -> illegal=1 for 1 cycle, out_valid stays 0.
REQ-039 SHALL cover: vsetvli with vlmul=100 -> vill=1, vl=0; a following vadd -> illegal=1.
REQ-040 SHALL cover: rst asserted while idx=1 of an m4 group -> next cycle out_valid=0, vl=0, in_ready=1.
